// File: rtl/reglist_onehot_sequencer.sv
// Register-select sequencer: decodes a single index (mode 0) or walks a register-list
// mask lowest-first (mode 1), presenting one one-hot select per valid/ready handshake.
module reglist_onehot_sequencer #(
  parameter int SEL_W = 4,
  localparam int N    = 2**SEL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [N-1:0]     list,
  input  logic             out_ready,
  output logic [N-1:0]     onehot,
  output logic             out_valid,
  output logic [SEL_W-1:0] out_index,
  output logic             out_last,
  output logic             busy,
  output logic [SEL_W:0]   count,
  output logic             done
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state, state_next;
  logic [N-1:0]     pending, pending_next;
  logic [N-1:0]     load;
  logic [N-1:0]     low_bit;
  logic [SEL_W-1:0] low_index;
  logic             single;
  logic [SEL_W:0]   count_next;
  logic             done_next;

  // Outputs come only from state/pending, so nothing moves while out_ready is low.
  assign low_bit = pending & (~pending + N'(1));
  assign single  = (pending & (pending - N'(1))) == '0;

  always_comb begin
    low_index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) low_index = SEL_W'(i);
    end
  end

  assign busy      = (state == EMIT);
  assign out_valid = busy;
  assign onehot    = busy ? low_bit : '0;
  assign out_index = busy ? low_index : '0;
  assign out_last  = busy && single;

  assign load = mode ? list : (N'(1) << sel);

  always_comb begin
    state_next   = state;
    pending_next = pending;
    count_next   = count;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          pending_next = load;
          count_next   = '0;
          if (load != '0) state_next = EMIT;
          else            done_next  = 1'b1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          pending_next = pending & ~low_bit;
          count_next   = count + (SEL_W+1)'(1);
          if (single) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
      count   <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      count   <= count_next;
      done    <= done_next;
    end
  end

endmodule

// File: tb/tb_reglist_onehot_sequencer.sv
// Randomised bench for reglist_onehot_sequencer; expected selects come from a
// list-of-set-bits model of each operation.
module tb_reglist_onehot_sequencer;
  localparam int SEL_W = 4;
  localparam int N     = 16;

  logic             clk = 1'b0;
  logic             reset, start, mode, out_ready;
  logic [SEL_W-1:0] sel;
  logic [N-1:0]     list;
  logic [N-1:0]     onehot;
  logic             out_valid, out_last, busy, done;
  logic [SEL_W-1:0] out_index;
  logic [SEL_W:0]   count;

  reglist_onehot_sequencer #(.SEL_W(SEL_W)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .sel(sel), .list(list),
    .out_ready(out_ready), .onehot(onehot), .out_valid(out_valid), .out_index(out_index),
    .out_last(out_last), .busy(busy), .count(count), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int          exp_idx[$];
  int          obs_idx[$];
  logic [15:0] obs_oh[$];
  bit          obs_last[$];
  int          inv_err, hold_err, done_delay, valid_cycles, done_cnt;
  bit          got_done, done_busy, done_valid;

  // Expected selects: set bits of the loaded mask, ascending.
  function automatic void build_model(input logic m, input logic [3:0] s, input logic [15:0] l);
    exp_idx.delete();
    if (!m) exp_idx.push_back(int'(s));
    else for (int i = 0; i < N; i++) if (l[i]) exp_idx.push_back(i);
  endfunction

  // Drives one operation and records what the DUT presents; the tests judge it.
  task automatic run_op(input logic m, input logic [3:0] s, input logic [15:0] l,
                        input int stall, input int pct, input bit spam);
    int   stall_left;
    bit   r, held;
    logic [15:0] prev_oh;
    logic prev_last;
    obs_idx.delete(); obs_oh.delete(); obs_last.delete();
    inv_err = 0; hold_err = 0; done_delay = 0; valid_cycles = 0; done_cnt = -1;
    got_done = 0; done_busy = 1; done_valid = 1;
    stall_left = stall; held = 0; prev_oh = '0; prev_last = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = m; sel = s; list = l; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (done) begin
        got_done = 1; done_delay = cyc; done_cnt = int'(count);
        done_busy = busy; done_valid = out_valid;
        break;
      end
      if (out_valid) begin
        valid_cycles++;
        if (onehot !== (16'h1 << out_index)) inv_err++;
        if (held && (onehot !== prev_oh || out_last !== prev_last)) hold_err++;
      end else if (onehot !== 16'h0) inv_err++;
      if (busy !== out_valid) inv_err++;
      r = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < pct);
      if (out_valid && stall_left > 0) stall_left--;
      out_ready = r;
      held = out_valid && !r;
      prev_oh = onehot; prev_last = out_last;
      if (out_valid && r) begin
        obs_idx.push_back(int'(out_index));
        obs_oh.push_back(onehot);
        obs_last.push_back(out_last);
      end
      if (spam) begin
        start = 1'($urandom_range(1)); mode = 1'($urandom_range(1));
        sel = 4'($urandom); list = 16'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode = 1'b0; sel = '0; list = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({onehot, out_valid, out_index, out_last, busy, count, done} !== '0) begin
      bad++; $display("FAIL reset_outputs: got oh=%h v=%b idx=%0d last=%b busy=%b cnt=%0d done=%b want all 0",
                      onehot, out_valid, out_index, out_last, busy, count, done);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_idle: got valid=%b done=%b want 0 0", out_valid, done);
    end
  endtask

  task automatic test_mode0();
    run_op(1'b0, 4'hB, 16'($urandom), 0, 100, 0);
    total++;
    if (obs_oh.size() != 1 || obs_oh[0] !== 16'h0800 || obs_idx[0] != 11 || obs_last[0] !== 1'b1) begin
      bad++; $display("FAIL mode0_select: got n=%0d oh=%h idx=%0d want n=1 oh=0800 idx=11 last=1",
                      obs_oh.size(), obs_oh.size() > 0 ? obs_oh[0] : 16'h0, obs_idx.size() > 0 ? obs_idx[0] : -1);
    end
    total++;
    if (!got_done || done_delay != 2 || done_cnt != 1 || done_busy !== 1'b0) begin
      bad++; $display("FAIL mode0_done: got done=%b delay=%0d cnt=%0d busy=%b want 1 2 1 0",
                      got_done, done_delay, done_cnt, done_busy);
    end
  endtask

  task automatic test_list();
    logic [15:0] want [4];
    int errs;
    want = '{16'h0001, 16'h0020, 16'h0400, 16'h8000};
    run_op(1'b1, 4'h0, 16'h8421, 0, 100, 0);
    errs = (obs_oh.size() == 4) ? 0 : 1;
    if (errs == 0)
      for (int j = 0; j < 4; j++)
        if (obs_oh[j] !== want[j] || obs_last[j] !== (j == 3)) errs++;
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL list_8421_seq: got n=%0d errs=%0d want 0001,0020,0400,8000 last on 8000",
                      obs_oh.size(), errs);
    end
    total++;
    if (!got_done || done_delay != 5 || done_cnt != 4 || inv_err != 0) begin
      bad++; $display("FAIL list_8421_done: got done=%b delay=%0d cnt=%0d inv=%0d want 1 5 4 0",
                      got_done, done_delay, done_cnt, inv_err);
    end
  endtask

  task automatic test_backpressure();
    int errs;
    run_op(1'b1, 4'h0, 16'h0006, 3, 100, 0);
    total++;
    if (valid_cycles != 5 || hold_err != 0 || obs_oh.size() != 2 || done_delay != 6) begin
      bad++; $display("FAIL bp_hold: got vcyc=%0d hold_err=%0d n=%0d delay=%0d want 5 0 2 6",
                      valid_cycles, hold_err, obs_oh.size(), done_delay);
    end
    total++;
    if (obs_oh.size() == 2 && (obs_oh[0] !== 16'h0002 || obs_oh[1] !== 16'h0004)) begin
      bad++; $display("FAIL bp_seq: got %h,%h want 0002,0004", obs_oh[0], obs_oh[1]);
    end
    build_model(1'b1, 4'h0, 16'hFFFF);
    run_op(1'b1, 4'h0, 16'hFFFF, 0, 70, 1);
    errs = (obs_idx.size() == exp_idx.size()) ? 0 : 1;
    if (errs == 0) foreach (exp_idx[j]) if (obs_idx[j] != exp_idx[j]) errs++;
    total++;
    if (errs != 0 || done_cnt != 16 || hold_err != 0) begin
      bad++; $display("FAIL ignored_start: got n=%0d errs=%0d cnt=%0d hold=%0d want 16 0 16 0",
                      obs_idx.size(), errs, done_cnt, hold_err);
    end
  endtask

  task automatic test_empty();
    run_op(1'b1, 4'h7, 16'h0000, 0, 100, 0);
    total++;
    if (!got_done || done_delay != 1 || valid_cycles != 0 || done_cnt != 0 || done_valid !== 1'b0) begin
      bad++; $display("FAIL empty_list: got done=%b delay=%0d vcyc=%0d cnt=%0d want 1 1 0 0",
                      got_done, done_delay, valid_cycles, done_cnt);
    end
  endtask

  task automatic test_full();
    int errs;
    run_op(1'b1, 4'h0, 16'hFFFF, 0, 100, 0);
    errs = (obs_idx.size() == 16) ? 0 : 1;
    if (errs == 0) for (int j = 0; j < 16; j++) if (obs_idx[j] != j || obs_last[j] !== (j == 15)) errs++;
    total++;
    if (errs != 0 || done_cnt != 16 || done_delay != 17) begin
      bad++; $display("FAIL full_list: got n=%0d errs=%0d cnt=%0d delay=%0d want 16 0 16 17",
                      obs_idx.size(), errs, done_cnt, done_delay);
    end
  endtask

  task automatic test_back_to_back();
    int seen, errs;
    bit hit;
    seen = 0; errs = 0; hit = 0;
    @(negedge clk);
    start = 1'b1; mode = 1'b1; list = 16'hFFFF; out_ready = 1'b1;
    @(negedge clk);
    list = 16'h0003;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done) begin hit = 1; break; end
      if (!out_valid || int'(out_index) != seen) errs++;
      seen++;
      @(negedge clk);
    end
    total++;
    if (!hit || seen != 16 || errs != 0 || count !== 5'd16) begin
      bad++; $display("FAIL b2b_first: got done=%b n=%0d errs=%0d cnt=%0d want 1 16 0 16", hit, seen, errs, count);
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (out_valid !== 1'b1 || onehot !== 16'h0001 || done !== 1'b0) begin
      bad++; $display("FAIL b2b_no_gap: got valid=%b oh=%h done=%b want 1 0001 0", out_valid, onehot, done);
    end
    @(negedge clk);
    total++;
    if (onehot !== 16'h0002 || out_last !== 1'b1) begin
      bad++; $display("FAIL b2b_second: got oh=%h last=%b want 0002 1", onehot, out_last);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || count !== 5'd2) begin
      bad++; $display("FAIL b2b_done: got done=%b cnt=%0d want 1 2", done, count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; mode = 1'b1; list = 16'h00F0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (onehot !== 16'h0040 || count !== 5'd2) begin
      bad++; $display("FAIL rst_mid_pre: got oh=%h cnt=%0d want 0040 2", onehot, count);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (onehot !== 16'h0 || out_valid !== 1'b0 || busy !== 1'b0 || count !== 5'd0 || done !== 1'b0) begin
      bad++; $display("FAIL rst_mid_outputs: got oh=%h v=%b busy=%b cnt=%0d done=%b want 0 0 0 0 0",
                      onehot, out_valid, busy, count, done);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid_nodone: got done=%b valid=%b want 0 0", done, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic        m;
    logic [3:0]  s;
    logic [15:0] l;
    int          errs;
    for (int it = 0; it < 30; it++) begin
      m = 1'($urandom_range(1));
      s = 4'($urandom);
      l = ($urandom_range(5) == 0) ? 16'h0 : 16'($urandom & $urandom);
      build_model(m, s, l);
      run_op(m, s, l, int'($urandom_range(2)), int'($urandom_range(100, 30)), bit'($urandom_range(1)));
      errs = (obs_idx.size() == exp_idx.size()) ? 0 : 1;
      if (errs == 0)
        foreach (exp_idx[j])
          if (obs_idx[j] != exp_idx[j] || obs_last[j] !== (j == exp_idx.size() - 1)) errs++;
      total++;
      if (errs != 0 || !got_done || done_cnt != exp_idx.size() || inv_err != 0 || hold_err != 0) begin
        bad++; $display("FAIL random_op%0d: mode=%b sel=%h list=%h got n=%0d errs=%0d done=%b cnt=%0d inv=%0d hold=%0d want n=%0d",
                        it, m, s, l, obs_idx.size(), errs, got_done, done_cnt, inv_err, hold_err, exp_idx.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_list();
    test_backpressure();
    test_empty();
    test_full();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reglist_onehot_sequencer.md
Name: reglist_onehot_sequencer

Overview:
Parametrised, registered successor to the register-select one-hot decoder. Mode 0 decodes a single binary register index to a one-hot select. Mode 1 walks an N-bit register-list mask (LDM/STM style), emitting one one-hot select per set bit, lowest index first, under a valid/ready handshake. It sits between the control unit and the register-file write-enable and read-select logic for multi-register transfers.

Parameters:
SEL_W, 4, width of binary register index; N = 2**SEL_W one-hot outputs (4 gives 16)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request a new operation; accepted only when busy=0
mode  input  1  0 = single decode of sel; 1 = register-list walk of list
sel  input  SEL_W  binary index (mode 0), sampled on accepted start
list  input  N  register-list mask (mode 1), sampled on accepted start; bit i = register i
out_ready  input  1  consumer accepts current select
onehot  output  N  one-hot select of current register; all zero when out_valid=0
out_valid  output  1  onehot/out_index valid
out_index  output  SEL_W  binary index of the bit set in onehot
out_last  output  1  current select is the final one of the operation
busy  output  1  operation in progress (state EMIT)
count  output  SEL_W+1  handshakes completed in current/last operation
done  output  1  one-cycle pulse: operation finished

Behaviour:
- Clock is clk. Reset is synchronous and active-high, named reset; it is sampled only on the rising edge of clk.
- Reset values: state=IDLE, pending=0, onehot=0, out_valid=0, out_index=0, out_last=0, busy=0, count=0, done=0.
- Internal register pending[N-1:0]. All outputs derive from registered state only; there is no combinational path from inputs to outputs.
- States: IDLE, EMIT.
- IDLE, start=1 (accepted start):
  - pending <= (mode ? list : 1<<sel); count <= 0.
  - If the loaded value is nonzero, go to EMIT.
  - If mode=1 and list=0, stay IDLE and pulse done next cycle; no out_valid is ever raised.
- IDLE, start=0: hold state; count keeps the value from the last operation.
- EMIT:
  - out_valid=1; onehot = lowest set bit of pending; out_index = its binary position.
  - out_last=1 iff pending has exactly one bit set.
  - On out_valid & out_ready: clear that bit of pending and increment count.
  - If out_last, go to IDLE and pulse done=1 in the following cycle.
  - If out_ready=0: onehot, out_index and out_last hold stable, with no glitches.
- Latency and throughput:
  - Accepted start at edge t gives out_valid=1 after edge t.
  - With out_ready held high, one select is produced per cycle; a k-bit list takes k cycles in EMIT.
  - Mode 0 always produces exactly one select.
- busy = (state==EMIT). start while busy=1 is ignored: sel, list and mode are not sampled and no error is raised.
- A new start is accepted in the same cycle that done is high, because the state is already IDLE.
- Mode 1, list=all ones: emits indices 0..N-1 in order; count ends at N, which fits in SEL_W+1 bits.
- Reset during EMIT: next cycle all outputs are at reset values; the partially walked list is discarded and done is not pulsed.
- Invariant: onehot has at most one bit set, and onehot == (out_valid ? 1<<out_index : 0).

Test Plan:
- Mode 0 with SEL_W=4: start with sel=4'hB, out_ready=1 -> next cycle onehot=16'h0800, out_index=11, out_last=1. Following cycle: done=1, busy=0, count=1.
- Mode 1, list=16'h8421, out_ready=1 -> onehot 0001, 0020, 0400, 8000 on four consecutive cycles. out_last is set only on 8000, then done is pulsed and count=4.
- Backpressure: list=16'h0006, out_ready low for 3 cycles then high -> onehot=0002 held stable for 4 cycles, then 0004, then done. Ignored start pulses during EMIT with list=16'hFFFF do not change the output sequence.
- Empty list: mode=1, list=0 -> out_valid never asserted; done=1 one cycle after start; count=0.
- Full list: list=16'hFFFF -> indices 0..15 in order, count=16 at done. start held high continuously -> the next operation begins in the done cycle with no idle gap.
- Reset mid-walk: list=16'h00F0, assert reset after the second handshake -> next cycle onehot=0, out_valid=0, busy=0, count=0, and no done pulse.
